register_tree_scheduler: RTL and testbench
==========================================

# register_tree_scheduler

Max-priority queue built on a register tree of `NODES = 2^LEVELS - 1` entries in heap order. A single shared `comparator` instance is time-multiplexed across tree nodes. The block owns the storage and occupancy count, and sequences the comparator through sift-up after enqueue and sift-down after dequeue. It is the control layer between producer/consumer handshakes and the register-tree compare-swap datapath.

## Interface
- `DATA_WIDTH`, 32, unsigned element width.
- `LEVELS`, 4, tree depth; `NODES = 2^LEVELS - 1` (15 by default).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enq_valid`  in  1  producer offers `enq_data`.
- `enq_data`  in  DATA_WIDTH  element to insert.
- `enq_ready`  out  1  high when state is IDLE, `!full`, and `!rst`.
- `deq_valid`  out  1  high when state is IDLE, `!empty`, and `!rst`.
- `deq_ready`  in  1  consumer accepts `deq_data`.
- `deq_data`  out  DATA_WIDTH  equals `tree[0]` (current maximum), combinational.
- `count`  out  $clog2(NODES+1)  number of stored elements.
- `full` / `empty`  out  1  `count == NODES` / `count == 0`.
- `busy`  out  1  state is not IDLE.

## Operation
- Storage `tree[0..NODES-1]`.
  - Children of node i are 2i+1 and 2i+2; parent is (i-1)>>1.
  - Unoccupied slots hold 0, so missing children never win a comparison.
- Comparator contract:
  - If the parent is ≥ both children, there is no change.
  - Otherwise the parent swaps with the larger child.
  - On a child tie, the left child is chosen.
  - Swap is detected as `new_parent != parent`.
- States: IDLE, SIFT_UP, SIFT_DOWN. Register `cur` holds the node under comparison.
- Enqueue fire (IDLE, `enq_valid & enq_ready`), no dequeue in the same cycle:
  - Writes `tree[count] <= enq_data` and `count++`.
  - If the old count was 0: stay in IDLE.
  - Otherwise: `cur <= parent(old count)`, go to SIFT_UP.
- SIFT_UP cycle:
  - Apply the comparator at `cur` and write back all three nodes.
  - If swapped and `cur != 0`: `cur <= parent(cur)`.
  - Otherwise: go to IDLE.
- Dequeue fire (IDLE, `deq_valid & deq_ready`), no enqueue in the same cycle:
  - `deq_data` is taken in this cycle.
  - Writes `tree[0] <= tree[count-1]`, then `tree[count-1] <= 0`; the clear wins when `count == 1`.
  - `count--`.
  - If the new count ≤ 1: stay in IDLE.
  - Otherwise: `cur <= 0`, go to SIFT_DOWN.
- SIFT_DOWN cycle:
  - Apply the comparator at `cur`.
  - If swapped, `cur <=` the child that received the old parent.
  - Go to IDLE if there was no swap, or if the new `cur ≥ 2^(LEVELS-1) - 1` (leaf).
- Simultaneous enqueue and dequeue fire (replace):
  - `deq_data` is the old root.
  - `tree[0] <= enq_data`; `count` is unchanged.
  - Go to SIFT_DOWN with `cur = 0` if `count > 1`, otherwise stay in IDLE.
- Full queue: `enq_ready = 0`, so a dequeue alone fires; no replace is possible while full.
- Values equal to 0 are legal data. Occupancy is tracked by `count`, not by value.

## Timing
- Reset, applied on the next edge regardless of state (including mid-sift):
  - All `tree` entries 0, `count` 0, state IDLE, `cur` 0.
  - While `rst` is high: `enq_ready = 0`, `deq_valid = 0`, `busy = 0`, `empty = 1`, `full = 0`, `deq_data = 0`.
- Enqueue: 1 handshake cycle, then at most LEVELS-1 SIFT_UP cycles.
- Dequeue and replace: 1 handshake cycle, then at most LEVELS-1 SIFT_DOWN cycles.
- Enqueue into an empty queue and dequeue down to ≤1 element take no sift cycles, so back-to-back handshakes are possible.
- `count`, `full` and `empty` update on the handshake edge.
- `deq_data` is valid for the new root on the first cycle `busy` is low.

## Structure
- Package `register_tree_pkg` holds:
  - The state enum typedef.
  - `NODES` and leaf-boundary constants, as functions of `LEVELS`.
  - Index functions `parent_idx`, `left_idx`, `right_idx`.
  - Default `DATA_WIDTH`.
- Sub-module: exactly one existing `comparator` instance.
  - Its inputs are muxed from `tree[cur]` and the two children of `cur`.
  - Its outputs are written back under FSM control.

## Test plan
- Reset → `count` 0, `empty` 1, `enq_ready`/`deq_valid` 0 while `rst` is high; `enq_ready` 1 on the first cycle after release.
- Enqueue 0x10, 0x20, 0x30 with `enq_valid` held → all accepted, `count` 3, `deq_data` 0x30 once `busy` falls.
- Dequeue three times from that state → 0x30, 0x20, 0x10 in order; then `empty` 1 and `deq_valid` 0.
- Enqueue 1..15 ascending → each enqueue has `busy` ≤3 cycles; `full` 1 and `enq_ready` 0 with `enq_valid` still high; draining yields 15 down to 1.
- Queue {0x40, 0x20, 0x30}, simultaneous enqueue 0x05 and dequeue → `deq_data` 0x40, `count` stays 3; later dequeues give 0x30, 0x20, 0x05.
- Enqueue 0x10 three times, assert `rst` during SIFT_UP of a fourth enqueue 0x50 → next cycle `count` 0, `deq_valid` 0, `busy` 0; all nodes read 0.

Source files
------------

// File: rtl/register_tree_pkg.sv
// register_tree_pkg
//   Shared types, sizing helpers and heap index arithmetic for the
//   register-tree priority queue.
//   Contents: state_t (scheduler FSM states), default widths/depth,
//   nodes_for/leaf_start_for (tree sizing from depth), parent/child index
//   functions for heap-ordered storage.
package register_tree_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LEVELS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SIFT_UP   = 2'd1,
        ST_SIFT_DOWN = 2'd2
    } state_t;

    function automatic int nodes_for(input int levels);
        return (1 << levels) - 1;
    endfunction

    // First index of the bottom row; nodes at or beyond it have no children.
    function automatic int leaf_start_for(input int levels);
        return (1 << (levels - 1)) - 1;
    endfunction

    localparam int DEFAULT_NODES      = nodes_for(DEFAULT_LEVELS);
    localparam int DEFAULT_LEAF_START = leaf_start_for(DEFAULT_LEVELS);

    function automatic int parent_idx(input int i);
        return (i - 1) >>> 1;
    endfunction

    function automatic int left_idx(input int i);
        return 2 * i + 1;
    endfunction

    function automatic int right_idx(input int i);
        return 2 * i + 2;
    endfunction

endpackage

// File: rtl/comparator.sv
// comparator
//   One heap compare-swap step on a parent and its two children.
//   Ports:
//     parent, left_child, right_child : current node values
//     new_parent, new_left, new_right : values to write back
//     pick_right                      : right child is the larger child
//   The larger child (left on a tie) replaces the parent only when it is
//   strictly greater; otherwise all three values pass through unchanged.
module comparator
    import register_tree_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] parent,
    input  logic [DATA_WIDTH-1:0] left_child,
    input  logic [DATA_WIDTH-1:0] right_child,
    output logic [DATA_WIDTH-1:0] new_parent,
    output logic [DATA_WIDTH-1:0] new_left,
    output logic [DATA_WIDTH-1:0] new_right,
    output logic                  pick_right
);

    logic [DATA_WIDTH-1:0] larger;

    always_comb begin
        pick_right = right_child > left_child;
        larger     = pick_right ? right_child : left_child;
        new_parent = parent;
        new_left   = left_child;
        new_right  = right_child;
        if (parent < larger) begin
            new_parent = larger;
            if (pick_right) begin
                new_right = parent;
            end else begin
                new_left = parent;
            end
        end
    end

endmodule

// File: rtl/register_tree_scheduler.sv
// register_tree_scheduler
//   Max-priority queue held in a heap-ordered register tree, with a single
//   time-shared comparator walked up the tree after an enqueue and down the
//   tree after a dequeue or replace.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     enq_valid/enq_ready  : producer handshake, enq_data inserted on fire
//     deq_valid/deq_ready  : consumer handshake, deq_data is the current max
//     count, full, empty   : occupancy
//     busy                 : a sift is in progress, handshakes are blocked
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_IDLE      | heap ordered, handshakes accepted
//   ST_SIFT_UP   | compare-swap at cur, then move cur toward the root
//   ST_SIFT_DOWN | compare-swap at cur, then follow the displaced value down
module register_tree_scheduler
    import register_tree_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEVELS     = DEFAULT_LEVELS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enq_valid,
    input  logic [DATA_WIDTH-1:0]              enq_data,
    output logic                               enq_ready,
    output logic                               deq_valid,
    input  logic                               deq_ready,
    output logic [DATA_WIDTH-1:0]              deq_data,
    output logic [$clog2(nodes_for(LEVELS)+1)-1:0] count,
    output logic                               full,
    output logic                               empty,
    output logic                               busy
);

    localparam int NODES      = nodes_for(LEVELS);
    localparam int LEAF_START = leaf_start_for(LEVELS);
    localparam int CNT_W      = $clog2(NODES + 1);

    logic [DATA_WIDTH-1:0] tree [NODES];
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cur;

    logic [CNT_W-1:0]      cnt_m1;
    logic [CNT_W-1:0]      cnt_parent;
    logic [CNT_W-1:0]      cur_parent;
    logic [CNT_W-1:0]      left_sel;
    logic [CNT_W-1:0]      right_sel;
    logic [CNT_W-1:0]      child_sel;
    logic                  left_ok;
    logic                  right_ok;
    logic                  is_full;
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  swapped;

    logic [DATA_WIDTH-1:0] cmp_parent;
    logic [DATA_WIDTH-1:0] cmp_left;
    logic [DATA_WIDTH-1:0] cmp_right;
    logic [DATA_WIDTH-1:0] new_parent;
    logic [DATA_WIDTH-1:0] new_left;
    logic [DATA_WIDTH-1:0] new_right;
    logic                  pick_right;

    // Children past the end of the array read as 0 so they never win.
    always_comb begin
        left_ok    = left_idx(int'(cur)) < NODES;
        right_ok   = right_idx(int'(cur)) < NODES;
        left_sel   = CNT_W'(left_idx(int'(cur)));
        right_sel  = CNT_W'(right_idx(int'(cur)));
        cmp_parent = tree[cur];
        cmp_left   = left_ok  ? tree[left_sel]  : '0;
        cmp_right  = right_ok ? tree[right_sel] : '0;
    end

    comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comparator (
        .parent      (cmp_parent),
        .left_child  (cmp_left),
        .right_child (cmp_right),
        .new_parent  (new_parent),
        .new_left    (new_left),
        .new_right   (new_right),
        .pick_right  (pick_right)
    );

    assign swapped    = new_parent != cmp_parent;
    assign child_sel  = pick_right ? right_sel : left_sel;
    assign cnt_m1     = cnt - CNT_W'(1);
    assign cnt_parent = CNT_W'(parent_idx(int'(cnt)));
    assign cur_parent = CNT_W'(parent_idx(int'(cur)));

    assign is_full   = cnt == CNT_W'(NODES);
    assign enq_ready = !rst && (state == ST_IDLE) && !is_full;
    assign deq_valid = !rst && (state == ST_IDLE) && (cnt != '0);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    assign deq_data = rst ? '0 : tree[0];
    assign count    = rst ? '0 : cnt;
    assign full     = !rst && is_full;
    assign empty    = rst || (cnt == '0);
    assign busy     = !rst && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tree  <= '{default: '0};
            cnt   <= '0;
            cur   <= '0;
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enq_fire && deq_fire) begin
                        // Replace: new value enters at the root, count unchanged.
                        tree[0] <= enq_data;
                        if (cnt > CNT_W'(1)) begin
                            cur   <= '0;
                            state <= ST_SIFT_DOWN;
                        end
                    end else if (enq_fire) begin
                        tree[cnt] <= enq_data;
                        cnt       <= cnt + CNT_W'(1);
                        if (cnt != '0) begin
                            cur   <= cnt_parent;
                            state <= ST_SIFT_UP;
                        end
                    end else if (deq_fire) begin
                        // With one element both writes hit node 0; the clear wins.
                        tree[0]      <= tree[cnt_m1];
                        tree[cnt_m1] <= '0;
                        cnt          <= cnt_m1;
                        if (cnt_m1 > CNT_W'(1)) begin
                            cur   <= '0;
                            state <= ST_SIFT_DOWN;
                        end
                    end
                end
                ST_SIFT_UP: begin
                    tree[cur] <= new_parent;
                    if (left_ok)  tree[left_sel]  <= new_left;
                    if (right_ok) tree[right_sel] <= new_right;
                    if (swapped && (cur != '0)) begin
                        cur <= cur_parent;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SIFT_DOWN: begin
                    tree[cur] <= new_parent;
                    if (left_ok)  tree[left_sel]  <= new_left;
                    if (right_ok) tree[right_sel] <= new_right;
                    if (swapped) begin
                        cur <= child_sel;
                        if (int'(child_sel) >= LEAF_START) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_tree_scheduler.sv
// tb_register_tree_scheduler
//   Directed bench for register_tree_scheduler. A multiset of queued values
//   serves as the reference: count is its size, the head is its maximum.
//   A negedge compare process checks occupancy, handshakes and the head
//   every cycle; directed sequences add literal expectations on popped data.
module tb_register_tree_scheduler;
    import register_tree_pkg::*;

    localparam int DW       = 32;
    localparam int LEVELS   = 4;
    localparam int NODES    = nodes_for(LEVELS);
    localparam int CW       = $clog2(NODES + 1);
    localparam int MAX_SIFT = LEVELS - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_valid = 1'b0;
    logic [DW-1:0] enq_data = '0;
    logic          deq_ready = 1'b0;
    logic          enq_ready;
    logic          deq_valid;
    logic [DW-1:0] deq_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;

    register_tree_scheduler #(
        .DATA_WIDTH (DW),
        .LEVELS     (LEVELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    int unsigned model[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_max();
        int unsigned m = 0;
        foreach (model[i]) if (model[i] > m) m = model[i];
        return m;
    endfunction

    function automatic void model_take_max();
        int unsigned m = model_max();
        foreach (model[i]) begin
            if (model[i] == m) begin
                model.delete(i);
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("count", count, model.size());
            check("empty", empty, model.size() == 0);
            check("full", full, model.size() == NODES);
            check("enq_ready", enq_ready, !busy && (model.size() != NODES));
            check("deq_valid", deq_valid, !busy && (model.size() != 0));
            if (!busy) check("deq_data", deq_data, model_max());
        end
    end

    task automatic settle(input string name);
        int b = 0;
        while (busy && b < 16) begin
            @(posedge clk); #1;
            b++;
        end
        check({name, " sift cycles"}, b <= MAX_SIFT, 1);
    endtask

    // Leaves enq_valid high on return so callers can stream held-valid pushes.
    task automatic push(input logic [DW-1:0] v);
        int w = 0;
        enq_valid = 1'b1;
        enq_data  = v;
        while (!enq_ready && w < 16) begin
            @(posedge clk); #1;
            w++;
        end
        check("push wait", enq_ready, 1);
        @(posedge clk); #1;
        model.push_back(v);
        settle("push");
    endtask

    task automatic pop(output logic [DW-1:0] v);
        int w = 0;
        deq_ready = 1'b1;
        while (!deq_valid && w < 16) begin
            @(posedge clk); #1;
            w++;
        end
        check("pop wait", deq_valid, 1);
        v = deq_data;
        @(posedge clk); #1;
        deq_ready = 1'b0;
        model_take_max();
        settle("pop");
    endtask

    task automatic replace(input logic [DW-1:0] v, output logic [DW-1:0] r);
        int w = 0;
        enq_valid = 1'b1;
        enq_data  = v;
        deq_ready = 1'b1;
        while (!(enq_ready && deq_valid) && w < 16) begin
            @(posedge clk); #1;
            w++;
        end
        check("replace wait", enq_ready && deq_valid, 1);
        r = deq_data;
        @(posedge clk); #1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        model_take_max();
        model.push_back(v);
        settle("replace");
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] exp);
        logic [DW-1:0] got;
        pop(got);
        check(name, got, exp);
    endtask

    initial begin
        logic [DW-1:0] r;

        // Reset held: outputs forced to their idle-empty values.
        repeat (3) @(posedge clk);
        #1;
        check("rst count", count, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst enq_ready", enq_ready, 0);
        check("rst deq_valid", deq_valid, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;
        #1;
        check("enq_ready after release", enq_ready, 1);
        chk_en = 1'b1;

        // Three held-valid pushes, max rises to the root.
        push(32'h10);
        push(32'h20);
        push(32'h30);
        enq_valid = 1'b0;
        check("count after 3 pushes", count, 3);
        check("head after 3 pushes", deq_data, 32'h30);

        pop_expect("pop 1 of 3", 32'h30);
        pop_expect("pop 2 of 3", 32'h20);
        pop_expect("pop 3 of 3", 32'h10);
        check("empty after drain", empty, 1);
        check("deq_valid after drain", deq_valid, 0);

        // Fill completely with ascending values, then push against full.
        for (int v = 1; v <= NODES; v++) push(DW'(v));
        enq_data = 32'h99;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("full when filled", full, 1);
        check("enq_ready when full", enq_ready, 0);
        check("count when full", count, NODES);
        enq_valid = 1'b0;
        for (int v = NODES; v >= 1; v--) pop_expect("drain ascending", DW'(v));
        check("empty after full drain", empty, 1);

        // Replace on a three-element heap.
        push(32'h40);
        push(32'h20);
        push(32'h30);
        enq_valid = 1'b0;
        replace(32'h05, r);
        check("replace returns old root", r, 32'h40);
        check("replace keeps count", count, 3);
        pop_expect("after replace 1", 32'h30);
        pop_expect("after replace 2", 32'h20);
        pop_expect("after replace 3", 32'h05);

        // Zero is a legal value; occupancy comes from count.
        push(32'h0);
        push(32'h7);
        enq_valid = 1'b0;
        check("count with zero element", count, 2);
        pop_expect("pop over zero", 32'h7);
        pop_expect("pop zero", 32'h0);
        check("empty after zero pop", empty, 1);

        // Replace with a single element stays idle.
        push(32'h9);
        enq_valid = 1'b0;
        replace(32'h3, r);
        check("replace single returns", r, 32'h9);
        check("replace single count", count, 1);
        check("replace single head", deq_data, 32'h3);
        pop_expect("pop after single replace", 32'h3);

        // Reset in the middle of a sift-up.
        push(32'h10);
        push(32'h10);
        push(32'h10);
        enq_data = 32'h50;
        begin
            int w = 0;
            while (!enq_ready && w < 16) begin
                @(posedge clk); #1;
                w++;
            end
        end
        @(posedge clk); #1;
        model.push_back(32'h50);
        check("sift-up in progress", busy, 1);
        chk_en    = 1'b0;
        rst       = 1'b1;
        enq_valid = 1'b0;
        #1;
        check("mid rst enq_ready", enq_ready, 0);
        check("mid rst deq_valid", deq_valid, 0);
        check("mid rst busy", busy, 0);
        check("mid rst empty", empty, 1);
        check("mid rst deq_data", deq_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model.delete();
        #1;
        check("post rst count", count, 0);
        check("post rst deq_valid", deq_valid, 0);
        check("post rst busy", busy, 0);
        for (int i = 0; i < NODES; i++) check("post rst node", dut.tree[i], 0);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
